video_pattern_generator: RTL

VIDEO_PATTERN_GENERATOR -- requirements
Module: video_pattern_generator

---
 rtl/video_pattern_generator.sv | 259 +++++++++++++++++++++++++
 1 files changed

// File: rtl/video_pattern_generator.sv
// Video test-pattern generator: solid fill, colour bars, ramp, checkerboard and bouncing box.
// Pixel colour and timing strobes share a fixed two-stage pipeline, so the colour stays aligned with its strobes.
module video_pattern_generator #(
    parameter int COLOR_DEPTH = 8,
    parameter int H_WIDTH     = 12,
    parameter int V_WIDTH     = 11,
    parameter int NUM_BARS    = 8
) (
    input  logic                   pixelClock,
    input  logic                   reset,
    input  logic                   dataEnable,
    input  logic                   hSync,
    input  logic                   vSync,
    input  logic                   activeVideoGuardBand,
    input  logic                   activeVideoPreamble,
    input  logic [H_WIDTH-1:0]     hPos,
    input  logic [V_WIDTH-1:0]     vPos,
    input  logic [H_WIDTH-1:0]     hActive,
    input  logic [V_WIDTH-1:0]     vActive,
    input  logic [2:0]             mode,
    input  logic [H_WIDTH-1:0]     barWidth,
    input  logic [3:0]             rampShift,
    input  logic [3:0]             checkerShift,
    input  logic [H_WIDTH-1:0]     boxSize,
    input  logic [COLOR_DEPTH-1:0] solidR,
    input  logic [COLOR_DEPTH-1:0] solidG,
    input  logic [COLOR_DEPTH-1:0] solidB,
    output logic [COLOR_DEPTH-1:0] r,
    output logic [COLOR_DEPTH-1:0] g,
    output logic [COLOR_DEPTH-1:0] b,
    output logic                   dataEnableDelayed,
    output logic                   hSyncDelayed,
    output logic                   vSyncDelayed,
    output logic                   activeVideoGuardBandDelayed,
    output logic                   activeVideoPreambleDelayed,
    output logic [15:0]            frameCount
);

    localparam int CW = ((H_WIDTH > V_WIDTH) ? H_WIDTH : V_WIDTH) + 1;
    localparam logic [2:0] LAST_BAR = 3'(NUM_BARS - 1);
    localparam logic [COLOR_DEPTH-1:0] FULL = '1;

    typedef enum logic [2:0] {
        MODE_SOLID   = 3'd0,
        MODE_BARS    = 3'd1,
        MODE_RAMP    = 3'd2,
        MODE_CHECKER = 3'd3,
        MODE_BOX     = 3'd4
    } pattern_mode_t;

    typedef struct packed {
        logic [CW-1:0] pos;
        logic          neg;
    } axis_t;

    // One box step per frame: bounce off an edge by flipping direction while holding position.
    function automatic axis_t step_axis(input logic [CW-1:0] pos, input logic neg,
                                        input logic [CW-1:0] size, input logic [CW-1:0] limit);
        axis_t res;
        res.pos = pos;
        res.neg = neg;
        if (size >= limit) begin
            res.pos = '0;
        end else if (!neg) begin
            if (pos + CW'(1) + size > limit) res.neg = 1'b1;
            else                             res.pos = pos + CW'(1);
        end else begin
            if (pos == '0) res.neg = 1'b0;
            else           res.pos = pos - CW'(1);
        end
        return res;
    endfunction

    function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
        case (idx)
            3'd0:    return 3'b111;
            3'd1:    return 3'b110;
            3'd2:    return 3'b011;
            3'd3:    return 3'b010;
            3'd4:    return 3'b101;
            3'd5:    return 3'b100;
            3'd6:    return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    logic                   prev_vsync, prev_de;
    pattern_mode_t          cfg_mode;
    logic [H_WIDTH-1:0]     cfg_bar_width, cfg_box_size;
    logic [3:0]             cfg_ramp_shift, cfg_checker_shift;
    logic [COLOR_DEPTH-1:0] cfg_r, cfg_g, cfg_b;
    logic [CW-1:0]          box_x, box_y;
    logic                   dir_x_neg, dir_y_neg;
    logic [H_WIDTH-1:0]     pix_cnt;
    logic [2:0]             bar_idx;

    logic                   frame_start, de_rise, bar_last, h_bit, v_bit, in_box;
    logic [H_WIDTH-1:0]     cur_pix, eff_width;
    logic [2:0]             cur_bar, bar_bits;
    axis_t                  next_x, next_y;
    logic [CW-1:0]          hx, vy;
    logic [COLOR_DEPTH-1:0] pix_r, pix_g, pix_b;

    logic                   s1_de, s1_hs, s1_vs, s1_gb, s1_pre;
    logic [COLOR_DEPTH-1:0] s1_r, s1_g, s1_b;

    assign frame_start = vSync & ~prev_vsync;
    assign de_rise     = dataEnable & ~prev_de;
    assign cur_pix     = de_rise ? '0 : pix_cnt;
    assign cur_bar     = de_rise ? '0 : bar_idx;
    assign eff_width   = (cfg_bar_width == '0) ? H_WIDTH'(1) : cfg_bar_width;
    assign bar_last    = (cur_pix == eff_width - H_WIDTH'(1));
    assign bar_bits    = bar_rgb(cur_bar);
    assign h_bit       = |(hPos & (H_WIDTH'(1) << cfg_checker_shift));
    assign v_bit       = |(vPos & (V_WIDTH'(1) << cfg_checker_shift));
    assign hx          = CW'(hPos);
    assign vy          = CW'(vPos);
    assign in_box      = (hx >= box_x) && (hx < box_x + CW'(cfg_box_size)) &&
                         (vy >= box_y) && (vy < box_y + CW'(cfg_box_size));
    assign next_x      = step_axis(box_x, dir_x_neg, CW'(boxSize), CW'(hActive));
    assign next_y      = step_axis(box_y, dir_y_neg, CW'(boxSize), CW'(vActive));

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        pix_r = '0;
        pix_g = '0;
        pix_b = '0;
        if (dataEnable) begin
            case (cfg_mode)
                MODE_SOLID: begin
                    pix_r = cfg_r;
                    pix_g = cfg_g;
                    pix_b = cfg_b;
                end
                MODE_BARS: begin
                    pix_r = {COLOR_DEPTH{bar_bits[2]}};
                    pix_g = {COLOR_DEPTH{bar_bits[1]}};
                    pix_b = {COLOR_DEPTH{bar_bits[0]}};
                end
                MODE_RAMP: begin
                    pix_r = COLOR_DEPTH'(hPos >> cfg_ramp_shift);
                    pix_g = COLOR_DEPTH'(hPos >> cfg_ramp_shift);
                    pix_b = COLOR_DEPTH'(hPos >> cfg_ramp_shift);
                end
                MODE_CHECKER: begin
                    if (h_bit ^ v_bit) begin
                        pix_r = FULL;
                        pix_g = FULL;
                        pix_b = FULL;
                    end
                end
                MODE_BOX: begin
                    pix_b = FULL;
                    if (in_box) begin
                        pix_r = FULL;
                        pix_g = FULL;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge pixelClock or negedge reset) begin
        if (!reset) begin
            prev_vsync        <= 1'b0;
            cfg_mode          <= MODE_SOLID;
            cfg_bar_width     <= '0;
            cfg_box_size      <= '0;
            cfg_ramp_shift    <= '0;
            cfg_checker_shift <= '0;
            cfg_r             <= '0;
            cfg_g             <= '0;
            cfg_b             <= '0;
            box_x             <= '0;
            box_y             <= '0;
            dir_x_neg         <= 1'b0;
            dir_y_neg         <= 1'b0;
            frameCount        <= '0;
        end else begin
            prev_vsync <= vSync;
            if (frame_start) begin
                cfg_mode          <= pattern_mode_t'(mode);
                cfg_bar_width     <= barWidth;
                cfg_box_size      <= boxSize;
                cfg_ramp_shift    <= rampShift;
                cfg_checker_shift <= checkerShift;
                cfg_r             <= solidR;
                cfg_g             <= solidG;
                cfg_b             <= solidB;
                box_x             <= next_x.pos;
                dir_x_neg         <= next_x.neg;
                box_y             <= next_y.pos;
                dir_y_neg         <= next_y.neg;
                frameCount        <= frameCount + 16'd1;
            end
        end
    end

    always_ff @(posedge pixelClock or negedge reset) begin
        if (!reset) begin
            prev_de <= 1'b0;
            pix_cnt <= '0;
            bar_idx <= '0;
        end else begin
            prev_de <= dataEnable;
            if (dataEnable) begin
                if (bar_last) begin
                    pix_cnt <= '0;
                    bar_idx <= (cur_bar == LAST_BAR) ? cur_bar : cur_bar + 3'd1;
                end else begin
                    pix_cnt <= cur_pix + H_WIDTH'(1);
                    bar_idx <= cur_bar;
                end
            end
        end
    end

    // NOTE: pipeline registers are cleared by the async reset so no stale pixel appears after release.
    always_ff @(posedge pixelClock or negedge reset) begin
        if (!reset) begin
            s1_de                       <= 1'b0;
            s1_hs                       <= 1'b0;
            s1_vs                       <= 1'b0;
            s1_gb                       <= 1'b0;
            s1_pre                      <= 1'b0;
            s1_r                        <= '0;
            s1_g                        <= '0;
            s1_b                        <= '0;
            dataEnableDelayed           <= 1'b0;
            hSyncDelayed                <= 1'b0;
            vSyncDelayed                <= 1'b0;
            activeVideoGuardBandDelayed <= 1'b0;
            activeVideoPreambleDelayed  <= 1'b0;
            r                           <= '0;
            g                           <= '0;
            b                           <= '0;
        end else begin
            s1_de                       <= dataEnable;
            s1_hs                       <= hSync;
            s1_vs                       <= vSync;
            s1_gb                       <= activeVideoGuardBand;
            s1_pre                      <= activeVideoPreamble;
            s1_r                        <= pix_r;
            s1_g                        <= pix_g;
            s1_b                        <= pix_b;
            dataEnableDelayed           <= s1_de;
            hSyncDelayed                <= s1_hs;
            vSyncDelayed                <= s1_vs;
            activeVideoGuardBandDelayed <= s1_gb;
            activeVideoPreambleDelayed  <= s1_pre;
            r                           <= s1_r;
            g                           <= s1_g;
            b                           <= s1_b;
        end
    end

endmodule
